// File: rtl/fmul_issue_arb.sv
// fmul_issue_arb: shares one pipelined FP32 multiplier (mul_top) between two
// requesters. Round-robin issue, in-flight tag tracking and a show-ahead
// response FIFO per requester. mul_top cannot stall, so issue is gated by
// credits: an op is only issued when its result is guaranteed a FIFO slot.
//
// Timing: an operand pair handshaken in cycle T has its product on mul_result
// during cycle T+LAT-1. It is captured on the LAT-th edge counting the issue
// edge as the first. rsp_valid therefore rises in cycle T+LAT. The tracker
// holds the tag through the LAT-1 register stages between those two edges.
module fmul_issue_arb #(
    parameter int W     = 32,
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_data,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_data,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    input  logic [W-1:0] mul_result,
    output logic         busy
);

    localparam int TS = (LAT > 1) ? LAT - 1 : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    genvar gi;

    logic [1:0]         req_valid;
    logic [1:0]         rsp_ready;
    logic [1:0]         rsp_valid;
    logic [1:0][W-1:0]  req_a;
    logic [1:0][W-1:0]  req_b;
    logic [1:0][W-1:0]  rsp_data;
    logic [1:0]         elig;
    logic [1:0]         grant;
    logic [1:0]         push;
    logic [1:0]         nonempty_d;
    logic               issue;
    logic               rr_q;
    logic               rr_d;
    logic               busy_q;
    logic               busy_d;
    logic [TS-1:0]      trk_vld_q;
    logic [TS-1:0]      trk_vld_d;
    logic [TS-1:0]      trk_tag_q;
    logic [TS-1:0]      trk_tag_d;

    assign req_valid = {req1_valid, req0_valid};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Grant: a lone eligible requester wins, a tie goes to the RR pointer.
    // Nothing is granted while reset is asserted, since the reset edge clears the tracker.
    always_comb begin
        grant = 2'b00;
        if (rst) begin
            if (elig == 2'b11) begin
                grant = rr_q ? 2'b10 : 2'b01;
            end else begin
                grant = elig;
            end
        end
    end

    assign issue      = |grant;
    assign rr_d       = issue ? ~rr_q : rr_q;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Multiplier operands follow the granted requester, zero when idle
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (grant[0]) begin
            mul_a = req_a[0];
            mul_b = req_b[0];
        end else if (grant[1]) begin
            mul_a = req_a[1];
            mul_b = req_b[1];
        end
    end

    // Tracker shift chain: stage 0 loads at the issue edge and the last stage
    // lines up with mul_result.
    generate
        for (gi = 0; gi < TS; gi++) begin : g_trk
            if (gi == 0) begin : g_head
                assign trk_vld_d[gi] = issue;
                assign trk_tag_d[gi] = grant[1];
            end else begin : g_body
                assign trk_vld_d[gi] = trk_vld_q[gi-1];
                assign trk_tag_d[gi] = trk_tag_q[gi-1];
            end
        end
    endgenerate

    assign push[0] = trk_vld_q[TS-1] && !trk_tag_q[TS-1];
    assign push[1] = trk_vld_q[TS-1] &&  trk_tag_q[TS-1];

    assign busy_d = (|trk_vld_d) || (|nonempty_d);
    assign busy   = busy_q;

    // Tracker, RR pointer and busy flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            trk_vld_q <= '0;
            trk_tag_q <= '0;
            rr_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            trk_vld_q <= trk_vld_d;
            trk_tag_q <= trk_tag_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
        end
    end

    // Per-requester credit accounting and response FIFO
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [W-1:0]  mem_q [DEPTH];
            logic [AW-1:0] wr_ptr_q;
            logic [AW-1:0] wr_ptr_d;
            logic [AW-1:0] rd_ptr_q;
            logic [AW-1:0] rd_ptr_d;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic [CW-1:0] infl_q;
            logic [CW-1:0] infl_d;
            logic          pop;

            // Registered counts only: a pop this cycle frees its credit next cycle
            assign elig[gi]      = req_valid[gi] &&
                                   (({1'b0, cnt_q} + {1'b0, infl_q}) < DEPTH_W);
            assign rsp_valid[gi] = (cnt_q != '0);
            assign rsp_data[gi]  = rsp_valid[gi] ? mem_q[rd_ptr_q] : '0;
            assign pop           = rsp_valid[gi] && rsp_ready[gi];
            assign nonempty_d[gi] = (cnt_d != '0);

            // Next-state counters and wrapping pointers
            always_comb begin
                cnt_d    = cnt_q + CW'(push[gi]) - CW'(pop);
                infl_d   = infl_q + CW'(grant[gi]) - CW'(push[gi]);
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (push[gi]) begin
                    wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
                end
            end

            // FIFO pointers, occupancy and in-flight count
            always_ff @(posedge clk) begin
                if (!rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                    infl_q   <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                    infl_q   <= infl_d;
                end
            end

            // Result storage, left unreset; stale entries are never visible
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem_q[wr_ptr_q] <= mul_result;
                end
            end

            // Credits guarantee a slot for every product that arrives
            a_no_full_push: assert property (@(posedge clk) disable iff (!rst)
                !(push[gi] && (cnt_q == CW'(DEPTH))));
        end
    endgenerate

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = rsp_data[0];
    assign rsp1_data  = rsp_data[1];

endmodule

// File: tb/tb_fmul_issue_arb.sv
// Directed bench for fmul_issue_arb with a behavioural mul_top model.
module tb_fmul_issue_arb;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic [W-1:0] mul_a, mul_b, mul_result;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fmul_issue_arb #(.W(W), .LAT(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .busy       (busy)
    );

    // mul_top stand-in: the two FP pairs used here give true FP32 products,
    // every other pair gives a+b so each product is distinct and traceable.
    function automatic logic [W-1:0] fmodel(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
        return a + b;
    endfunction

    // Product of the pair presented in cycle T is on mul_result in cycle T+3
    logic [W-1:0] mpipe [3];
    always_ff @(posedge clk) begin
        if (!rst) begin
            mpipe[0] <= '0;
            mpipe[1] <= '0;
            mpipe[2] <= '0;
        end else begin
            mpipe[0] <= fmodel(mul_a, mul_b);
            mpipe[1] <= mpipe[0];
            mpipe[2] <= mpipe[1];
        end
    end
    assign mul_result = mpipe[2];

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2;
        req1_valid = 1'b1; req1_a = 32'h3; req1_b = 32'h4;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready: got %b expected 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_ready: got %b expected 0", req1_ready); end
        checks++; if (mul_a !== 32'h0) begin errors++; $display("FAIL rst_mul_a: got %h expected 0", mul_a); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b%b expected 00", rsp1_valid, rsp0_valid); end
        checks++; if (rsp0_data !== 32'h0) begin errors++; $display("FAIL rst_rsp0_data: got %h expected 0", rsp0_data); end
        next_cycle();
        rst = 1'b1;
        clear_inputs();
        req0_valid = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_credits_full: got %b expected 1", req0_ready); end
        req0_valid = 1'b0;
        next_cycle();
        $display("test_reset: done");
    endtask

    task automatic test_single_op();
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", req0_ready); end
        checks++; if (mul_a !== 32'h40000000 || mul_b !== 32'h40400000) begin errors++; $display("FAIL single_operands: got %h %h expected 40000000 40400000", mul_a, mul_b); end
        next_cycle();
        clear_inputs();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (rsp0_valid !== (c == 4)) begin errors++; $display("FAIL single_rsp0_valid c%0d: got %b expected %b", c, rsp0_valid, (c == 4)); end
            checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1_valid c%0d: got %b expected 0", c, rsp1_valid); end
            if (c == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
                checks++; if (mul_a !== 32'h0) begin errors++; $display("FAIL single_idle_mul_a: got %h expected 0", mul_a); end
            end
            if (c == 4) begin
                checks++; if (rsp0_data !== 32'h40C00000) begin errors++; $display("FAIL single_data: got %h expected 40c00000", rsp0_data); end
                $display("test_single_op: rsp0 %h in cycle T+%0d", rsp0_data, c);
            end
            if (c == 5) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
            end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        logic         v0 [10];
        logic         v1 [10];
        logic [W-1:0] a0 [10];
        logic [W-1:0] b0 [10];
        logic [W-1:0] a1 [10];
        logic [W-1:0] b1 [10];
        logic [1:0]   eg [10];
        logic         e0v [10];
        logic         e1v [10];
        logic [W-1:0] e0d [10];
        logic [W-1:0] e1d [10];
        logic [W-1:0] emul;
        v0  = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        a0  = '{32'h100, 32'h200, 32'h200, 32'h400, 32'h400, 0, 0, 0, 0, 0};
        b0  = '{32'h11, 32'h22, 32'h22, 32'h44, 32'h44, 0, 0, 0, 0, 0};
        v1  = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        a1  = '{32'h3FC00000, 32'h3FC00000, 32'h300, 32'h300, 0, 0, 0, 0, 0, 0};
        b1  = '{32'h3FC00000, 32'h3FC00000, 32'h33, 32'h33, 0, 0, 0, 0, 0, 0};
        eg  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        e0v = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
        e0d = '{0, 0, 0, 0, 32'h111, 0, 32'h222, 0, 32'h444, 0};
        e1v = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
        e1d = '{0, 0, 0, 0, 0, 32'h40100000, 0, 32'h333, 0, 0};
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req0_valid = v0[c]; req0_a = a0[c]; req0_b = b0[c];
            req1_valid = v1[c]; req1_a = a1[c]; req1_b = b1[c];
            emul = eg[c][0] ? a0[c] : (eg[c][1] ? a1[c] : '0);
            @(negedge clk);
            checks++; if ({req1_ready, req0_ready} !== eg[c]) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, {req1_ready, req0_ready}, eg[c]); end
            checks++; if (mul_a !== emul) begin errors++; $display("FAIL rr_mul_a c%0d: got %h expected %h", c, mul_a, emul); end
            checks++; if (rsp0_valid !== e0v[c] || rsp1_valid !== e1v[c]) begin errors++; $display("FAIL rr_rsp_valid c%0d: got %b%b expected %b%b", c, rsp1_valid, rsp0_valid, e1v[c], e0v[c]); end
            if (e0v[c]) begin
                checks++; if (rsp0_data !== e0d[c]) begin errors++; $display("FAIL rr_rsp0_data c%0d: got %h expected %h", c, rsp0_data, e0d[c]); end
            end
            if (e1v[c]) begin
                checks++; if (rsp1_data !== e1d[c]) begin errors++; $display("FAIL rr_rsp1_data c%0d: got %h expected %h", c, rsp1_data, e1d[c]); end
            end
            if (c == 9) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_end: got %b expected 0", busy); end
            end
            $display("test_round_robin c%0d: grant=%b rsp0=%b/%h rsp1=%b/%h", c, {req1_ready, req0_ready}, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data);
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_credit_limit();
        logic ereq [10];
        int   k;
        ereq = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        k = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req0_valid = 1'b1;
            req0_a = 32'h10 * (k + 1);
            req0_b = 32'h1;
            rsp0_ready = (c == 8);
            @(negedge clk);
            checks++; if (req0_ready !== ereq[c]) begin errors++; $display("FAIL credit_ready c%0d: got %b expected %b", c, req0_ready, ereq[c]); end
            if (c == 8) begin
                checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h11) begin errors++; $display("FAIL credit_head: got %b/%h expected 1/00000011", rsp0_valid, rsp0_data); end
            end
            if (c == 9) begin
                checks++; if (rsp0_data !== 32'h21) begin errors++; $display("FAIL credit_after_pop: got %h expected 00000021", rsp0_data); end
            end
            if (ereq[c]) k++;
            next_cycle();
        end
        clear_inputs();
        $display("test_credit_limit: %0d issues accepted", k);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req0_valid = 1'b1; req0_a = 32'h1000 + c; req0_b = 32'h1;
            next_cycle();
        end
        req0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midflight_busy_before: got %b expected 1", busy); end
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL midflight_rsp c%0d: got %b%b expected 00", c, rsp1_valid, rsp0_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midflight_busy c%0d: got %b expected 0", c, busy); end
            next_cycle();
        end
        req0_valid = 1'b1; req0_a = 32'h2000; req0_b = 32'h2;
        req1_valid = 1'b1; req1_a = 32'h3000; req1_b = 32'h3;
        @(negedge clk);
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL midflight_rr: got %b expected 01", {req1_ready, req0_ready}); end
        next_cycle();
        clear_inputs();
        $display("test_reset_midflight: done");
    endtask

    task automatic test_push_pop_wrap();
        logic [W-1:0] exp_q [$];
        int k;
        int nrsp;
        k = 0;
        nrsp = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(fmodel(32'h100 * (i + 1), W'(i)));
        do_reset();
        for (int c = 0; c < 40; c++) begin
            req0_valid = (k < 8);
            req0_a = 32'h100 * (k + 1);
            req0_b = W'(k);
            rsp0_ready = (c >= 5);
            @(negedge clk);
            if (c == 4 || c == 5) begin
                checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL pp_ready_low c%0d: got %b expected 0", c, req0_ready); end
            end
            if (c == 6) begin
                checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL pp_ready_back: got %b expected 1", req0_ready); end
                checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h201) begin errors++; $display("FAIL pp_same_edge: got %b/%h expected 1/00000201", rsp0_valid, rsp0_data); end
            end
            if (req0_valid && req0_ready) k++;
            if (rsp0_valid && rsp0_ready) begin
                checks++;
                if (nrsp >= 8) begin
                    errors++; $display("FAIL pp_extra_rsp: got %h expected none", rsp0_data);
                end else if (rsp0_data !== exp_q[nrsp]) begin
                    errors++; $display("FAIL pp_order #%0d: got %h expected %h", nrsp, rsp0_data, exp_q[nrsp]);
                end
                $display("test_push_pop_wrap: rsp #%0d = %h", nrsp, rsp0_data);
                nrsp++;
            end
            next_cycle();
        end
        checks++; if (nrsp !== 8) begin errors++; $display("FAIL pp_count: got %0d expected 8", nrsp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pp_busy_end: got %b expected 0", busy); end
        clear_inputs();
    endtask

    task automatic test_single_requester_rr();
        logic         v0 [7];
        logic         v1 [7];
        logic [W-1:0] a0 [7];
        logic [W-1:0] a1 [7];
        logic [W-1:0] b0 [7];
        logic [W-1:0] b1 [7];
        logic [1:0]   eg [7];
        logic [W-1:0] emul [7];
        v0   = '{0, 1, 1, 0, 0, 0, 0};
        a0   = '{0, 32'h600, 32'h600, 0, 0, 0, 0};
        b0   = '{0, 32'h66, 32'h66, 0, 0, 0, 0};
        v1   = '{1, 1, 1, 0, 0, 0, 0};
        a1   = '{32'h500, 32'h700, 32'h800, 0, 0, 0, 0};
        b1   = '{32'h55, 32'h77, 32'h88, 0, 0, 0, 0};
        eg   = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        emul = '{32'h500, 32'h700, 32'h600, 0, 0, 0, 0};
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req0_valid = v0[c]; req0_a = a0[c]; req0_b = b0[c];
            req1_valid = v1[c]; req1_a = a1[c]; req1_b = b1[c];
            @(negedge clk);
            checks++; if ({req1_ready, req0_ready} !== eg[c]) begin errors++; $display("FAIL solo_grant c%0d: got %b expected %b", c, {req1_ready, req0_ready}, eg[c]); end
            checks++; if (mul_a !== emul[c]) begin errors++; $display("FAIL solo_mul_a c%0d: got %h expected %h", c, mul_a, emul[c]); end
            if (c == 4) begin
                checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h555) begin errors++; $display("FAIL solo_rsp1: got %b/%h expected 1/00000555", rsp1_valid, rsp1_data); end
            end
            if (c == 5) begin
                checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'h777) begin errors++; $display("FAIL solo_rsp1b: got %b/%h expected 1/00000777", rsp1_valid, rsp1_data); end
            end
            if (c == 6) begin
                checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h666) begin errors++; $display("FAIL solo_rsp0: got %b/%h expected 1/00000666", rsp0_valid, rsp0_data); end
            end
            $display("test_single_requester_rr c%0d: grant=%b mul_a=%h", c, {req1_ready, req0_ready}, mul_a);
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single_op();
        test_round_robin();
        test_credit_limit();
        test_reset_midflight();
        test_push_pop_wrap();
        test_single_requester_rr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
